// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing, coordinate and colour constants
package vga_pkg;

    localparam int COORD_W = 10;

    // 640x480@60 raster timing
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // 4:4:4 RGB colours used by the colour driver
    localparam int              COLOR_W     = 12;
    localparam logic [COLOR_W-1:0] COLOR_BLACK = 12'h000;
    localparam logic [COLOR_W-1:0] COLOR_WHITE = 12'hFFF;
    localparam logic [COLOR_W-1:0] COLOR_RED   = 12'hF00;
    localparam logic [COLOR_W-1:0] COLOR_GREEN = 12'h0F0;
    localparam logic [COLOR_W-1:0] COLOR_BLUE  = 12'h00F;

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - N-deep 1-bit shift register with async reset value
module sync_delay_line #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stages;

    // Shift every clock; reset flushes every stage so no stale pulse survives
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            stages <= {DEPTH{RST_VAL}};
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing, coordinates and frame strobes
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV    = 4,
    parameter int   H_ACTIVE   = H_ACTIVE_DEF,
    parameter int   H_FP       = H_FP_DEF,
    parameter int   H_SYNC     = H_SYNC_DEF,
    parameter int   H_BP       = H_BP_DEF,
    parameter int   V_ACTIVE   = V_ACTIVE_DEF,
    parameter int   V_FP       = V_FP_DEF,
    parameter int   V_SYNC     = V_SYNC_DEF,
    parameter int   V_BP       = V_BP_DEF,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   SYNC_DELAY = 2
) (
    input  logic               clk_in,
    input  logic               reset,
    output logic [COORD_W-1:0] current_row,
    output logic [COORD_W-1:0] current_line,
    output logic               enable,
    output logic               pixel_tick,
    output logic               hsync,
    output logic               vsync,
    output logic               vblank,
    output logic               frame_start
);

    localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DELAY_DEPTH = (SYNC_DELAY > 0) ? SYNC_DELAY : 1;
    localparam int H_TOT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT       = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] v_count;
    logic               wrapped;
    logic               hsync_raw;
    logic               vsync_raw;

    assign tick = (div_cnt == DIV_LAST);

    // Pixel-rate divider
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Raster counters; wrapped marks that the counters just rolled over to (0,0)
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
            wrapped <= 1'b0;
        end else if (tick) begin
            wrapped <= (h_count == H_LAST) && (v_count == V_LAST);
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    // Coordinates and qualifiers for the pixel that begins on this tick
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            current_row  <= '0;
            current_line <= '0;
            enable       <= 1'b0;
            vblank       <= 1'b0;
            pixel_tick   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            pixel_tick  <= tick;
            frame_start <= tick && wrapped;
            if (tick) begin
                current_row  <= h_count;
                current_line <= v_count;
                enable       <= (h_count < H_ACT) && (v_count < V_ACT);
                vblank       <= (v_count >= V_ACT);
            end
        end
    end

    // Sync levels follow the registered coordinates, then get delayed to match color_out
    assign hsync_raw = ((current_row >= HS_START) && (current_row < HS_END))
                       ? SYNC_POL : ~SYNC_POL;
    assign vsync_raw = ((current_line >= VS_START) && (current_line < VS_END))
                       ? SYNC_POL : ~SYNC_POL;

    sync_delay_line #(
        .DEPTH   (DELAY_DEPTH),
        .RST_VAL (~SYNC_POL)
    ) u_hsync_delay (
        .clk_in (clk_in),
        .reset  (reset),
        .din    (hsync_raw),
        .dout   (hsync)
    );

    sync_delay_line #(
        .DEPTH   (DELAY_DEPTH),
        .RST_VAL (~SYNC_POL)
    ) u_vsync_delay (
        .clk_in (clk_in),
        .reset  (reset),
        .din    (vsync_raw),
        .dout   (vsync)
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    logic reset_c = 1'b1;

    logic [9:0] row_a, line_a, row_b, line_b, row_c, line_c;
    logic enable_a, pixel_tick_a, hsync_a, vsync_a, vblank_a, frame_start_a;
    logic enable_b, pixel_tick_b, hsync_b, vsync_b, vblank_b, frame_start_b;
    logic enable_c, pixel_tick_c, hsync_c, vsync_c, vblank_c, frame_start_c;

    // a: full 640x480 timing; b: shrunken raster 24x12, same divider/delay; c: shrunken, CLK_DIV=1, SYNC_DELAY=0
    vga_timing_gen u_dut_a (
        .clk_in(clk_in), .reset(reset_a), .current_row(row_a), .current_line(line_a),
        .enable(enable_a), .pixel_tick(pixel_tick_a), .hsync(hsync_a), .vsync(vsync_a),
        .vblank(vblank_a), .frame_start(frame_start_a)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0), .SYNC_DELAY(2)
    ) u_dut_b (
        .clk_in(clk_in), .reset(reset_b), .current_row(row_b), .current_line(line_b),
        .enable(enable_b), .pixel_tick(pixel_tick_b), .hsync(hsync_b), .vsync(vsync_b),
        .vblank(vblank_b), .frame_start(frame_start_b)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0), .SYNC_DELAY(0)
    ) u_dut_c (
        .clk_in(clk_in), .reset(reset_c), .current_row(row_c), .current_line(line_c),
        .enable(enable_c), .pixel_tick(pixel_tick_c), .hsync(hsync_c), .vsync(vsync_c),
        .vblank(vblank_c), .frame_start(frame_start_c)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the negedge right after the tick that presents (r,l) on instance sel
    task automatic wait_pix(input int sel, input int r, input int l, input string tag);
        bit hit;
        logic pt;
        logic [9:0] rr, ll;
        hit = 1'b0;
        for (int n = 0; n < 20000 && !hit; n++) begin
            @(negedge clk_in);
            case (sel)
                0:       begin pt = pixel_tick_a; rr = row_a; ll = line_a; end
                1:       begin pt = pixel_tick_b; rr = row_b; ll = line_b; end
                default: begin pt = pixel_tick_c; rr = row_c; ll = line_c; end
            endcase
            hit = pt && (rr == 10'(r)) && (ll == 10'(l));
        end
        check(tag, hit, 1);
    endtask

    initial begin
        int n;
        int vb_cnt, vs_cnt, fs_cnt, vb_rise_line, vs_fall_line;
        logic prev_vb, prev_vs;

        repeat (3) @(negedge clk_in);

        // ---------------- instance a: reset release and first line ----------------
        check("a_reset_row", row_a, 0);
        check("a_reset_enable", enable_a, 0);
        check("a_reset_hsync", hsync_a, 1);
        reset_a = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_in);
            check("a_pre_enable", enable_a, 0);
            check("a_pre_tick", pixel_tick_a, 0);
            check("a_pre_hsync", hsync_a, 1);
            check("a_pre_vsync", vsync_a, 1);
        end
        @(negedge clk_in);
        check("a_first_tick", pixel_tick_a, 1);
        check("a_first_enable", enable_a, 1);
        check("a_first_row", row_a, 0);
        check("a_first_line", line_a, 0);

        n = 0;
        do begin @(negedge clk_in); n++; end while (!pixel_tick_a && n < 20);
        check("a_pixel_period", n, 4);
        check("a_second_row", row_a, 1);

        wait_pix(0, 639, 0, "a_reach_639");
        check("a_enable_639", enable_a, 1);
        wait_pix(0, 640, 0, "a_reach_640");
        check("a_enable_640", enable_a, 0);
        check("a_vblank_line0", vblank_a, 0);

        wait_pix(0, 656, 0, "a_reach_656");
        check("a_hs_lag0", hsync_a, 1);
        @(negedge clk_in);
        check("a_hs_lag1", hsync_a, 1);
        @(negedge clk_in);
        check("a_hs_lag2", hsync_a, 0);
        n = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_in);
            if (hsync_a) break;
            n++;
        end
        check("a_hs_width", n, 384);
        wait_pix(0, 0, 1, "a_line1");
        check("a_line1_enable", enable_a, 1);

        // ---------------- instance b: frame-level timing ----------------
        @(negedge clk_in);
        reset_b = 1'b0;
        repeat (3) @(negedge clk_in);
        check("b_pre_enable", enable_b, 0);
        @(negedge clk_in);
        check("b_first_tick", pixel_tick_b, 1);
        check("b_first_enable", enable_b, 1);
        check("b_first_fs", frame_start_b, 0);

        vb_cnt = 0; vs_cnt = 0; fs_cnt = 0; vb_rise_line = -1; vs_fall_line = -1;
        prev_vb = vblank_b; prev_vs = vsync_b;
        for (int k = 1; k <= 1152; k++) begin
            @(negedge clk_in);
            if (vblank_b) vb_cnt++;
            if (!vsync_b) vs_cnt++;
            if (frame_start_b) fs_cnt++;
            if (vblank_b && !prev_vb) vb_rise_line = int'(line_b);
            if (!vsync_b && prev_vs) vs_fall_line = int'(line_b);
            prev_vb = vblank_b;
            prev_vs = vsync_b;
        end
        check("b_vblank_cycles", vb_cnt, 576);
        check("b_vsync_cycles", vs_cnt, 192);
        check("b_fs_count", fs_cnt, 1);
        check("b_vblank_rise_line", vb_rise_line, 6);
        check("b_vsync_fall_line", vs_fall_line, 8);
        check("b_wrap_fs", frame_start_b, 1);
        check("b_wrap_row", row_b, 0);
        check("b_wrap_line", line_b, 0);
        @(negedge clk_in);
        check("b_fs_width", frame_start_b, 0);
        n = 1;
        while (!frame_start_b && n < 5000) begin @(negedge clk_in); n++; end
        check("b_frame_period", n, 1152);

        wait_pix(1, 23, 2, "b_reach_23_2");
        n = 0;
        do begin @(negedge clk_in); n++; end while (!pixel_tick_b && n < 20);
        check("b_next_row", row_b, 0);
        check("b_next_line", line_b, 3);
        check("b_next_fs", frame_start_b, 0);

        // Reset in the middle of hsync and vsync
        wait_pix(1, 20, 9, "b_reach_20_9");
        @(negedge clk_in);
        @(negedge clk_in);
        check("b_pre_rst_hsync", hsync_b, 0);
        check("b_pre_rst_vsync", vsync_b, 0);
        #2 reset_b = 1'b1;
        #1;
        check("b_rst_hsync", hsync_b, 1);
        check("b_rst_vsync", vsync_b, 1);
        check("b_rst_row", row_b, 0);
        check("b_rst_line", line_b, 0);
        check("b_rst_enable", enable_b, 0);
        check("b_rst_vblank", vblank_b, 0);
        @(negedge clk_in);
        reset_b = 1'b0;
        repeat (3) @(negedge clk_in);
        check("b_rerun_pre_enable", enable_b, 0);
        check("b_rerun_pre_hsync", hsync_b, 1);
        @(negedge clk_in);
        check("b_rerun_tick", pixel_tick_b, 1);
        check("b_rerun_enable", enable_b, 1);
        check("b_rerun_row", row_b, 0);

        // ---------------- instance c: CLK_DIV=1, SYNC_DELAY=0 ----------------
        reset_c = 1'b0;
        @(negedge clk_in);
        check("c_first_tick", pixel_tick_c, 1);
        check("c_first_enable", enable_c, 1);
        check("c_row0", row_c, 0);
        @(negedge clk_in);
        check("c_row1", row_c, 1);
        check("c_tick_stays", pixel_tick_c, 1);
        @(negedge clk_in);
        check("c_row2", row_c, 2);
        wait_pix(2, 18, 0, "c_reach_18");
        check("c_hs_lag0", hsync_c, 1);
        @(negedge clk_in);
        check("c_hs_lag1", hsync_c, 0);
        check("c_row19", row_c, 19);
        n = 0;
        while (!frame_start_c && n < 1000) begin @(negedge clk_in); n++; end
        check("c_fs_seen", frame_start_c, 1);
        n = 0;
        do begin @(negedge clk_in); n++; end while (!frame_start_c && n < 1000);
        check("c_frame_period", n, 288);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
